multicycle_ctrl: RTL and testbench

//  Control FSM for the multicycle 32-bit MIPS-subset datapath. Each cycle it drives the datapath
//  mux selects (ALU A/B source, PC source 3:1, reg-dest 5-bit 2:1, mem-to-reg 2:1) and the

---
 rtl/multicycle_ctrl.sv | 166 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS-subset datapath (R-type, lw, sw, beq, j, addi).
// Moore selects per state; pc_en, ir_write and illegal are Mealy on mem_ready/zero/opcode.
module multicycle_ctrl #(
    parameter bit WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RWB    = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t state_q, state_d;
    logic   rdy;

    // With waiting disabled every memory access completes in its first cycle.
    assign rdy   = mem_ready | ~WAIT_EN;
    assign state = state_q;

    // State register; reset returns to FETCH and aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and output decode; everything is forced low while reset is held.
    always_comb begin
        state_d    = S_FETCH;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        pc_src     = 2'd0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = rdy;
                pc_en     = rdy;
                state_d   = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                alu_src_b = 2'd3;
                case (opcode)
                    OP_R:         state_d = S_RCOMP;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = rdy ? S_FETCH : S_MEMWR;
            end
            S_RCOMP: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_src    = 2'd1;
                pc_en     = zero;
            end
            S_JUMP: begin
                pc_src = 2'd2;
                pc_en  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        if (!rst_n) begin
            pc_en      = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'd0;
            alu_op     = 2'd0;
            pc_src     = 2'd0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each instruction into its
// expected per-cycle state/output trace, which is compared against the DUT cycle by cycle.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en, iord, mem_read, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       illegal;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero, mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    int nvec = 0;
    int nerr = 0;

    exp_t q_exp[$];
    logic q_rdy[$];
    logic q_z[$];

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired nvec=%0d", nvec);
        $fatal(1, "watchdog");
    end

    function automatic exp_t sample();
        return {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

    task automatic push(input exp_t e, input logic r, input logic z);
        q_exp.push_back(e);
        q_rdy.push_back(r);
        q_z.push_back(z);
    endtask

    // Expand one instruction into its cycle trace: wf fetch wait cycles, wm memory wait cycles.
    task automatic build(input logic [5:0] op, input logic z, input int wf, input int wm);
        exp_t e;
        for (int i = 0; i <= wf; i++) begin
            e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'd1;
            if (i == wf) begin e.ir_write = 1'b1; e.pc_en = 1'b1; end
            push(e, i == wf, 1'($urandom));
        end
        e = '0; e.st = 4'd1; e.alu_src_b = 2'd3;
        if (!is_legal(op)) begin
            e.illegal = 1'b1;
            push(e, 1'($urandom), 1'($urandom));
            return;
        end
        push(e, 1'($urandom), 1'($urandom));
        case (op)
            OP_LW, OP_SW: begin
                e = '0; e.st = 4'd2; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                push(e, 1'($urandom), 1'($urandom));
                for (int i = 0; i <= wm; i++) begin
                    e = '0; e.iord = 1'b1;
                    if (op == OP_LW) begin e.st = 4'd3; e.mem_read = 1'b1; end
                    else begin e.st = 4'd5; e.mem_write = 1'b1; end
                    push(e, i == wm, 1'($urandom));
                end
                if (op == OP_LW) begin
                    e = '0; e.st = 4'd4; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                    push(e, 1'($urandom), 1'($urandom));
                end
            end
            OP_R: begin
                e = '0; e.st = 4'd7; e.alu_src_a = 1'b1; e.alu_op = 2'd2;
                push(e, 1'($urandom), 1'($urandom));
                e = '0; e.st = 4'd6; e.reg_write = 1'b1; e.reg_dst = 1'b1;
                push(e, 1'($urandom), 1'($urandom));
            end
            OP_BEQ: begin
                e = '0; e.st = 4'd8; e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.pc_src = 2'd1;
                e.pc_en = z;
                push(e, 1'($urandom), z);
            end
            OP_J: begin
                e = '0; e.st = 4'd9; e.pc_src = 2'd2; e.pc_en = 1'b1;
                push(e, 1'($urandom), 1'($urandom));
            end
            default: begin
                e = '0; e.st = 4'd10; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                push(e, 1'($urandom), 1'($urandom));
                e = '0; e.st = 4'd11; e.reg_write = 1'b1;
                push(e, 1'($urandom), 1'($urandom));
            end
        endcase
    endtask

    // Drive one cycle of inputs just after a rising edge, sample on the falling edge.
    task automatic cycle(input logic r, input logic z, output exp_t o);
        mem_ready = r;
        zero      = z;
        @(negedge clk);
        o = sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t o, e;
        rst_n = 1'b0; opcode = OP_SW; mem_ready = 1'b1; zero = 1'b1;
        #3;
        o = sample(); nvec++;
        if (o !== '0) begin nerr++; $display("FAIL reset_init got %h exp 0", o); end
        @(posedge clk); @(posedge clk); #1;
        mem_ready = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'd1;
        o = sample(); nvec++;
        if (o !== e) begin nerr++; $display("FAIL reset_release got %h exp %h", o, e); end
        @(posedge clk); #1;
        // run sw into MEMWR then abort it with reset
        build(OP_SW, 1'b0, 0, 3);
        for (int i = 0; i < 3; i++) begin
            e = q_exp.pop_front();
            cycle(q_rdy.pop_front(), q_z.pop_front(), o); nvec++;
            if (o !== e) begin nerr++; $display("FAIL reset_sw cyc%0d got %h exp %h", i, o, e); end
        end
        q_exp.delete(); q_rdy.delete(); q_z.delete();
        mem_ready = 1'b0;
        #1;
        nvec++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            nerr++; $display("FAIL reset_pre_memwr got st=%0d mw=%b exp st=5 mw=1", state, mem_write);
        end
        mem_ready = 1'b1; zero = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        o = sample(); nvec++;
        if (o !== '0) begin nerr++; $display("FAIL reset_async got %h exp 0", o); end
        @(posedge clk); #1;
        o = sample(); nvec++;
        if (o !== '0) begin nerr++; $display("FAIL reset_hold got %h exp 0", o); end
        mem_ready = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'd1;
        o = sample(); nvec++;
        if (o !== e) begin nerr++; $display("FAIL reset_refetch got %h exp %h", o, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        exp_t o, e;
        int n = 0;
        opcode = OP_LW;
        build(OP_LW, 1'b0, 0, 0);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            cycle(q_rdy.pop_front(), q_z.pop_front(), o); nvec++;
            if (o !== e) begin nerr++; $display("FAIL lw cyc%0d got %h exp %h", n, o, e); end
            n++;
        end
        nvec++;
        if (n !== 5) begin nerr++; $display("FAIL lw_latency got %0d exp 5", n); end
    endtask

    task automatic test_sw_wait();
        exp_t o, e;
        int n = 0, n5 = 0;
        opcode = OP_SW;
        build(OP_SW, 1'b0, 0, 3);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            cycle(q_rdy.pop_front(), q_z.pop_front(), o); nvec++;
            if (o !== e) begin nerr++; $display("FAIL sw_wait cyc%0d got %h exp %h", n, o, e); end
            if (o.st == 4'd5 && o.mem_write) n5++;
            n++;
        end
        nvec++;
        if (n5 !== 4) begin nerr++; $display("FAIL sw_hold got %0d exp 4", n5); end
        nvec++;
        if (state !== 4'd0) begin nerr++; $display("FAIL sw_return got %0d exp 0", state); end
    endtask

    task automatic test_beq();
        exp_t o, e;
        for (int zz = 1; zz >= 0; zz--) begin
            opcode = OP_BEQ;
            build(OP_BEQ, 1'(zz), 0, 0);
            while (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                cycle(q_rdy.pop_front(), q_z.pop_front(), o); nvec++;
                if (o !== e) begin nerr++; $display("FAIL beq_z%0d got %h exp %h", zz, o, e); end
            end
        end
    endtask

    task automatic test_fetch_wait();
        exp_t o, e;
        int n = 0;
        opcode = OP_J;
        build(OP_J, 1'b0, 2, 0);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            cycle(q_rdy.pop_front(), q_z.pop_front(), o); nvec++;
            if (o !== e) begin nerr++; $display("FAIL fetch_wait cyc%0d got %h exp %h", n, o, e); end
            n++;
        end
    endtask

    task automatic test_illegal_rtype();
        exp_t o, e;
        int n = 0;
        opcode = 6'b111111;
        build(6'b111111, 1'b0, 0, 0);
        build(OP_R, 1'b0, 0, 0);
        while (q_exp.size() > 0) begin
            if (n == 2) opcode = OP_R;
            e = q_exp.pop_front();
            cycle(q_rdy.pop_front(), q_z.pop_front(), o); nvec++;
            if (o !== e) begin nerr++; $display("FAIL illegal_r cyc%0d got %h exp %h", n, o, e); end
            n++;
        end
    endtask

    task automatic test_random();
        exp_t o, e;
        logic [5:0] ops [7];
        logic [5:0] op;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, 6'b0};
        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(6)];
            if (op == 6'b0 && $urandom_range(1) == 1) op = 6'($urandom);
            opcode = op;
            build(op, 1'($urandom), $urandom_range(3), $urandom_range(3));
            while (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                cycle(q_rdy.pop_front(), q_z.pop_front(), o); nvec++;
                if (o !== e) begin
                    nerr++; $display("FAIL random k%0d op=%b got %h exp %h", k, op, o, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_fetch_wait();
        test_illegal_rtype();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
